// File: rtl/priority_dec_2_4_v__hold_pkg.sv
// Shared definitions for the priority decoder receive channel.
// Holds the FSM state encoding, the default code width shared with the
// matching priority encoder, and the hold/gap counter sizing helper.
package priority_dec_2_4_v__hold_pkg;

    // Code width shared with the request-side 4-2 priority encoder.
    localparam int unsigned CODE_W_DEF = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    // Counter must hold the larger of the two reload values without wrapping.
    function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                              input int unsigned gap_cycles);
        int unsigned top_v;
        top_v = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        return 32'($clog2(top_v + 1));
    endfunction

endpackage

// File: rtl/priority_dec_2_4_v__hold_line_decode.sv
// Combinational one-hot line decoder.
// Ports:
//   i_code    in   CODE_W  index of the line to select
//   o_line_c  out  OUT_W   one-hot decode of i_code (combinational)
module priority_dec_2_4_v__hold_line_decode
    import priority_dec_2_4_v__hold_pkg::*;
#(
    parameter int unsigned CODE_W = CODE_W_DEF,
    parameter int unsigned OUT_W  = 1 << CODE_W
) (
    input  logic [CODE_W-1:0] i_code,
    output logic [OUT_W-1:0]  o_line_c
);

    assign o_line_c = OUT_W'(1) << i_code;

endmodule

// File: rtl/priority_dec_2_4_v__hold.sv
// Receive end of the priority-encoder channel: drives one select line for a
// fixed hold time, then an all-low break-before-make gap. A one-entry buffer
// with a ready/valid handshake absorbs a request arriving during hold/gap.
// Ports:
//   i_clk    in   1       clock
//   i_rst    in   1       synchronous active-high reset
//   i_code   in   CODE_W  index of line to assert
//   i_valid  in   1       i_code is a real request
//   o_ready  out  1       a request can be accepted this cycle
//   o_line   out  OUT_W   registered one-hot select, zero when idle or in gap
//   o_busy   out  1       hold or gap in progress
//   o_done   out  1       pulse during the final hold cycle of each request
module priority_dec_2_4_v__hold
    import priority_dec_2_4_v__hold_pkg::*;
#(
    parameter int unsigned CODE_W      = CODE_W_DEF,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [CODE_W-1:0]      i_code,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [(1<<CODE_W)-1:0] o_line,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int unsigned OUT_W     = 1 << CODE_W;
    localparam int unsigned CNT_W     = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int unsigned HOLD_LOAD = HOLD_CYCLES - 1;
    localparam int unsigned GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                buf_valid_q, buf_valid_d;
    logic [CODE_W-1:0]   buf_code_q, buf_code_d;
    logic [OUT_W-1:0]    line_q, line_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;

    logic                xfer;
    logic                load_pt;
    logic [OUT_W-1:0]    dec_line_c;

    assign xfer = i_valid & ready_q;

    // A new request may start only when the current one (hold, plus gap if any) is finishing.
    assign load_pt = (state_q == S_IDLE)
                   || ((state_q == S_GAP)  && (cnt_q == '0))
                   || ((state_q == S_HOLD) && (cnt_q == '0) && (GAP_CYCLES == 0));

    priority_dec_2_4_v__hold_line_decode #(
        .CODE_W (CODE_W),
        .OUT_W  (OUT_W)
    ) u_line_decode (
        .i_code   (code_d),
        .o_line_c (dec_line_c)
    );

    // Next-state, buffer and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        buf_valid_d = buf_valid_q;
        buf_code_d  = buf_code_q;

        unique case (state_q)
            S_IDLE: ;
            S_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (GAP_CYCLES > 0) begin
                    state_d = S_GAP;
                    cnt_d   = CNT_W'(GAP_LOAD);
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Buffered request wins over a bypass; ready is low whenever the buffer is full.
        if (load_pt) begin
            if (buf_valid_q) begin
                state_d     = S_HOLD;
                cnt_d       = CNT_W'(HOLD_LOAD);
                code_d      = buf_code_q;
                buf_valid_d = 1'b0;
            end else if (xfer) begin
                state_d = S_HOLD;
                cnt_d   = CNT_W'(HOLD_LOAD);
                code_d  = i_code;
            end else begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        end else if (xfer) begin
            buf_valid_d = 1'b1;
            buf_code_d  = i_code;
        end

        // Outputs registered from next-state so they line up with the state they describe.
        line_d  = (state_d == S_HOLD) ? dec_line_c : '0;
        done_d  = (state_d == S_HOLD) && (cnt_d == '0);
        busy_d  = (state_d != S_IDLE);
        ready_d = !buf_valid_d;
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            code_q      <= '0;
            buf_valid_q <= 1'b0;
            buf_code_q  <= '0;
            line_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            buf_valid_q <= buf_valid_d;
            buf_code_q  <= buf_code_d;
            line_q      <= line_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign o_line  = line_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_ready = ready_q;

endmodule

// File: tb/tb_priority_dec_2_4_v__hold.sv
// Bench for priority_dec_2_4_v__hold: GAP_CYCLES=1 instance (a) and GAP_CYCLES=0 instance (b).
module tb_priority_dec_2_4_v__hold;

    typedef struct packed {
        logic [3:0] line;
        logic       busy;
        logic       done;
        logic       ready;
    } out_t;

    typedef struct {
        int         dut;
        logic       rst;
        logic       valid;
        logic [1:0] code;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, valid_a = 1'b0;
    logic [1:0] code_a = 2'b00;
    logic       rst_b = 1'b1, valid_b = 1'b0;
    logic [1:0] code_b = 2'b00;
    logic       ready_a, busy_a, done_a, ready_b, busy_b, done_b;
    logic [3:0] line_a, line_b;

    int   n_checks = 0;
    int   n_errors = 0;
    int   row_no   = 0;
    out_t exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    priority_dec_2_4_v__hold #(.CODE_W(2), .HOLD_CYCLES(4), .GAP_CYCLES(1)) dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_code(code_a), .i_valid(valid_a),
        .o_ready(ready_a), .o_line(line_a), .o_busy(busy_a), .o_done(done_a)
    );

    priority_dec_2_4_v__hold #(.CODE_W(2), .HOLD_CYCLES(4), .GAP_CYCLES(0)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_code(code_b), .i_valid(valid_b),
        .o_ready(ready_b), .o_line(line_b), .o_busy(busy_b), .o_done(done_b)
    );

    function automatic vec_t mk(input int dut, input logic rst, input logic valid,
                                input logic [1:0] code, input logic [3:0] line,
                                input logic busy, input logic done, input logic ready);
        vec_t v;
        v.dut   = dut;
        v.rst   = rst;
        v.valid = valid;
        v.code  = code;
        v.exp   = '{line: line, busy: busy, done: done, ready: ready};
        return v;
    endfunction

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got %b, expected %b", name, row_no, act, exp);
        end
    endtask

    // Drive one row before the edge, push its expectation, compare #1 after the edge.
    task automatic run_row(input vec_t v);
        out_t e, a;
        if (v.dut == 0) begin
            rst_a = v.rst; valid_a = v.valid; code_a = v.code;
        end else begin
            rst_b = v.rst; valid_b = v.valid; code_b = v.code;
        end
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        a = (v.dut == 0) ? '{line: line_a, busy: busy_a, done: done_a, ready: ready_a}
                         : '{line: line_b, busy: busy_b, done: done_b, ready: ready_b};
        e = exp_q.pop_front();
        cmp((v.dut == 0) ? "a.line"  : "b.line",  a.line, e.line);
        cmp((v.dut == 0) ? "a.busy"  : "b.busy",  {3'b000, a.busy},  {3'b000, e.busy});
        cmp((v.dut == 0) ? "a.done"  : "b.done",  {3'b000, a.done},  {3'b000, e.done});
        cmp((v.dut == 0) ? "a.ready" : "b.ready", {3'b000, a.ready}, {3'b000, e.ready});
        row_no++;
    endtask

    initial begin
        // Reset held two cycles, then release.
        tbl.push_back(mk(0, 1, 0, 2'b00, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 2'b00, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2'b00, 4'b0000, 0, 0, 1));
        // No request with a nonzero code: nothing moves.
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 0, 0, 2'b11, 4'b0000, 0, 0, 1));
        // Single request code 10.
        tbl.push_back(mk(0, 0, 1, 2'b10, 4'b0100, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 4'b0100, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 4'b0100, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 4'b0100, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 4'b0000, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 4'b0000, 0, 0, 1));
        // Code 01 then code 11 buffered during hold.
        tbl.push_back(mk(0, 0, 1, 2'b01, 4'b0010, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 2'b11, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2'b00, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2'b00, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'b00, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2'b00, 4'b1000, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 4'b1000, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 4'b1000, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 4'b1000, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 4'b0000, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 4'b0000, 0, 0, 1));

        #1;
        foreach (tbl[i]) run_row(tbl[i]);

        // Reset mid-hold with the buffer full: lines drop, buffered code is discarded.
        run_row(mk(0, 0, 1, 2'b01, 4'b0010, 1, 0, 1));
        run_row(mk(0, 0, 1, 2'b10, 4'b0010, 1, 0, 0));
        run_row(mk(0, 1, 0, 2'b00, 4'b0000, 0, 0, 0));
        run_row(mk(0, 0, 0, 2'b00, 4'b0000, 0, 0, 1));
        for (int i = 0; i < 8; i++)
            run_row(mk(0, 0, 0, 2'b00, 4'b0000, 0, 0, 1));

        // No gap: same code twice back-to-back stays high for 8 contiguous cycles.
        run_row(mk(1, 1, 0, 2'b00, 4'b0000, 0, 0, 0));
        run_row(mk(1, 0, 0, 2'b00, 4'b0000, 0, 0, 1));
        run_row(mk(1, 0, 1, 2'b00, 4'b0001, 1, 0, 1));
        run_row(mk(1, 0, 1, 2'b00, 4'b0001, 1, 0, 0));
        run_row(mk(1, 0, 0, 2'b00, 4'b0001, 1, 0, 0));
        run_row(mk(1, 0, 0, 2'b00, 4'b0001, 1, 1, 0));
        run_row(mk(1, 0, 0, 2'b00, 4'b0001, 1, 0, 1));
        run_row(mk(1, 0, 0, 2'b00, 4'b0001, 1, 0, 1));
        run_row(mk(1, 0, 0, 2'b00, 4'b0001, 1, 0, 1));
        run_row(mk(1, 0, 0, 2'b00, 4'b0001, 1, 1, 1));
        run_row(mk(1, 0, 0, 2'b00, 4'b0000, 0, 0, 1));

        // No gap, different codes: new line follows the old one with no zero cycle.
        run_row(mk(1, 0, 1, 2'b10, 4'b0100, 1, 0, 1));
        run_row(mk(1, 0, 1, 2'b01, 4'b0100, 1, 0, 0));
        run_row(mk(1, 0, 0, 2'b00, 4'b0100, 1, 0, 0));
        run_row(mk(1, 0, 0, 2'b00, 4'b0100, 1, 1, 0));
        run_row(mk(1, 0, 0, 2'b00, 4'b0010, 1, 0, 1));
        run_row(mk(1, 0, 0, 2'b00, 4'b0010, 1, 0, 1));
        run_row(mk(1, 0, 0, 2'b00, 4'b0010, 1, 0, 1));
        run_row(mk(1, 0, 0, 2'b00, 4'b0010, 1, 1, 1));
        run_row(mk(1, 0, 0, 2'b00, 4'b0000, 0, 0, 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
